// File: rtl/ram2e_sdram_responder_if.sv
// Controller-to-SDRAM pin bundle for the RAM2E responder: command/address/data pins plus
// the responder's status outputs.
interface ram2e_sdram_responder_if;
  logic        CKE;
  logic        nCS;
  logic        nRAS;
  logic        nCAS;
  logic        nRWE;
  logic [1:0]  BA;
  logic [11:0] RA;
  logic        DQML;
  logic        DQMH;
  logic [7:0]  RDin;
  logic [7:0]  RDout;
  logic        RDoe;
  logic        Ready;
  logic [1:0]  CasLat;
  logic        ErrInit;
  logic        ErrProto;
  logic        ErrMode;
  logic        ErrRef;
  logic [15:0] RefCount;

  modport master (
    output CKE, nCS, nRAS, nCAS, nRWE, BA, RA, DQML, DQMH, RDin,
    input  RDout, RDoe, Ready, CasLat, ErrInit, ErrProto, ErrMode, ErrRef, RefCount
  );

  modport slave (
    input  CKE, nCS, nRAS, nCAS, nRWE, BA, RA, DQML, DQMH, RDin,
    output RDout, RDoe, Ready, CasLat, ErrInit, ErrProto, ErrMode, ErrRef, RefCount
  );
endinterface

// File: rtl/ram2e_sdram_responder.sv
// Device-side SDR SDRAM model for the RAM2E command bus: init tracking, bank state,
// byte-lane storage, CAS-latency read pipeline and sticky protocol error flags.
module ram2e_sdram_responder #(
  parameter int unsigned COL_BITS = 8,
  parameter int unsigned ROW_BITS = 4,
  parameter int unsigned REF_MAX  = 1024
) (
  input  logic                    C14M,
  input  logic                    nRST,
  ram2e_sdram_responder_if.slave  bus
);

  localparam int unsigned ADDR_W = 2 + ROW_BITS + COL_BITS;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned GAP_W  = $clog2(REF_MAX + 1) + 1;

  typedef enum logic [2:0] {
    S_WAIT_PC, S_WAIT_LMR, S_WAIT_REF1, S_WAIT_REF2, S_READY
  } state_t;

  state_t state, state_d;

  logic                           cke_r;
  logic                           ready_q;
  logic [1:0]                     cas_lat;
  logic                           err_init, err_proto, err_mode, err_ref;
  logic [15:0]                    ref_count;
  logic [GAP_W-1:0]               gap;
  logic [3:0]                     bank_open;
  logic [3:0][ROW_BITS-1:0]       bank_row;
  logic [2:0]                     pv;
  logic [2:0][1:0]                pb;
  logic [2:0][7:0]                pd;
  logic                           rdoe_q;
  logic [7:0]                     rdout_q;

  logic [7:0] mem_lo [DEPTH];
  logic [7:0] mem_hi [DEPTH];

  logic              cmd_v_c;
  logic [2:0]        cmd_c;
  logic              is_act, is_rd, is_wr, is_pre, is_aref, is_lmr;
  logic              any_open_c, bank_hit_c, rd_go_c, wr_go_c;
  logic [ADDR_W-1:0] addr_c;
  logic              rd_oe_c;
  logic [7:0]        rd_data_c;
  logic [2:0]        kill_c;
  logic              unused_ra;

  // Command decode is suppressed entirely while the clock is suspended
  always_comb begin
    cmd_v_c    = cke_r & ~bus.nCS;
    cmd_c      = {bus.nRAS, bus.nCAS, bus.nRWE};
    is_act     = cmd_v_c && (cmd_c == 3'b011);
    is_rd      = cmd_v_c && (cmd_c == 3'b101);
    is_wr      = cmd_v_c && (cmd_c == 3'b100);
    is_pre     = cmd_v_c && (cmd_c == 3'b010);
    is_aref    = cmd_v_c && (cmd_c == 3'b001);
    is_lmr     = cmd_v_c && (cmd_c == 3'b000);
    any_open_c = |bank_open;
    bank_hit_c = bank_open[bus.BA];
    rd_go_c    = is_rd && ready_q && bank_hit_c;
    wr_go_c    = is_wr && ready_q && bank_hit_c;
    addr_c     = {bus.BA, bank_row[bus.BA], bus.RA[COL_BITS-1:0]};
    rd_oe_c    = ~bus.DQML | ~bus.DQMH;
    rd_data_c  = !bus.DQML ? mem_lo[addr_c] : (!bus.DQMH ? mem_hi[addr_c] : 8'h00);
    for (int i = 0; i < 3; i++) begin
      kill_c[i] = (is_wr && (pb[i] == bus.BA)) ||
                  (is_pre && (bus.RA[10] || (pb[i] == bus.BA)));
    end
    unused_ra  = ^bus.RA;
  end

  // Init sequencing: PRE all -> LMR -> AREF -> AREF -> READY
  always_comb begin
    state_d = state;
    case (state)
      S_WAIT_PC:   if (is_pre && bus.RA[10]) state_d = S_WAIT_LMR;
      S_WAIT_LMR:  if (is_lmr)               state_d = S_WAIT_REF1;
      S_WAIT_REF1: if (is_aref)              state_d = S_WAIT_REF2;
      S_WAIT_REF2: if (is_aref)              state_d = S_READY;
      S_READY:                               state_d = S_READY;
      default:                               state_d = S_WAIT_PC;
    endcase
  end

  always_ff @(posedge C14M or negedge nRST) begin
    if (!nRST) begin
      state   <= S_WAIT_PC;
      ready_q <= 1'b0;
    end else begin
      state   <= state_d;
      ready_q <= (state_d == S_READY);
    end
  end

  // Mode, bank state, refresh bookkeeping and sticky errors
  always_ff @(posedge C14M or negedge nRST) begin
    if (!nRST) begin
      cke_r     <= 1'b0;
      cas_lat   <= 2'd2;
      err_init  <= 1'b0;
      err_proto <= 1'b0;
      err_mode  <= 1'b0;
      err_ref   <= 1'b0;
      ref_count <= '0;
      gap       <= '0;
      bank_open <= '0;
      bank_row  <= '0;
    end else begin
      cke_r <= bus.CKE;

      if (is_aref)        gap <= '0;
      else if (gap != '1) gap <= gap + GAP_W'(1);
      if (ready_q && (gap > GAP_W'(REF_MAX))) err_ref <= 1'b1;

      if ((is_act || is_rd || is_wr) && !ready_q) err_init <= 1'b1;
      if (ready_q && is_act && bank_hit_c) err_proto <= 1'b1;
      if (ready_q && (is_rd || is_wr) && !bank_hit_c) err_proto <= 1'b1;
      if ((is_lmr || is_aref) && any_open_c) err_proto <= 1'b1;

      if (is_lmr) begin
        if ((bus.RA[6:4] == 3'd2) || (bus.RA[6:4] == 3'd3)) cas_lat <= bus.RA[5:4];
        else                                                err_mode <= 1'b1;
        if ((bus.RA[2:0] != 3'd0) || bus.RA[7] || (bus.BA != 2'd0)) err_mode <= 1'b1;
      end

      if (is_aref && (ref_count != 16'hFFFF)) ref_count <= ref_count + 16'd1;

      if (ready_q && is_act) begin
        bank_open[bus.BA] <= 1'b1;
        bank_row[bus.BA]  <= bus.RA[ROW_BITS-1:0];
      end
      if (is_pre) begin
        if (bus.RA[10]) bank_open         <= '0;
        else            bank_open[bus.BA] <= 1'b0;
      end
    end
  end

  // Storage survives reset, so it sits outside the reset domain
  always_ff @(posedge C14M) begin
    if (wr_go_c) begin
      if (!bus.DQML) mem_lo[addr_c] <= bus.RDin;
      if (!bus.DQMH) mem_hi[addr_c] <= bus.RDin;
    end
  end

  // Read pipeline: stage 0 feeds the output; a read enters at stage CasLat-1
  always_ff @(posedge C14M or negedge nRST) begin
    if (!nRST) begin
      pv      <= '0;
      pb      <= '0;
      pd      <= '0;
      rdoe_q  <= 1'b0;
      rdout_q <= '0;
    end else if (cke_r) begin
      rdoe_q  <= pv[0] & ~kill_c[0];
      rdout_q <= pd[0];
      pv[0]   <= pv[1] & ~kill_c[1];
      pb[0]   <= pb[1];
      pd[0]   <= pd[1];
      pv[1]   <= pv[2] & ~kill_c[2];
      pb[1]   <= pb[2];
      pd[1]   <= pd[2];
      pv[2]   <= 1'b0;
      if (rd_go_c) begin
        if (cas_lat == 2'd3) begin
          pv[2] <= rd_oe_c;
          pb[2] <= bus.BA;
          pd[2] <= rd_data_c;
        end else begin
          pv[1] <= rd_oe_c;
          pb[1] <= bus.BA;
          pd[1] <= rd_data_c;
        end
      end
    end
  end

  assign bus.RDout    = rdout_q;
  assign bus.RDoe     = rdoe_q;
  assign bus.Ready    = ready_q;
  assign bus.CasLat   = cas_lat;
  assign bus.ErrInit  = err_init;
  assign bus.ErrProto = err_proto;
  assign bus.ErrMode  = err_mode;
  assign bus.ErrRef   = err_ref;
  assign bus.RefCount = ref_count;

endmodule

// File: tb/tb_ram2e_sdram_responder.sv
// Directed bench for ram2e_sdram_responder: stimulus queues expected reads, a negedge
// monitor matches every RDoe cycle against the queue (data and arrival edge).
module tb_ram2e_sdram_responder;

  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_LMR = 3'b000;

  typedef struct {
    logic [7:0]  data;
    int unsigned at;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #35 clk = ~clk;

  ram2e_sdram_responder_if bus ();

  ram2e_sdram_responder dut (
    .C14M (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Tracks whether the most recent edge was clock-enabled (CKE registered one edge late)
  logic ckr_m = 1'b0;
  logic last_en = 1'b0;
  always @(posedge clk) begin
    last_en <= ckr_m;
    ckr_m   <= bus.CKE;
  end

  exp_t        q[$];
  exp_t        mon_e;
  logic [7:0]  held = 8'h00;
  int          checks = 0;
  int          passes = 0;
  int unsigned cl = 2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] ba, input logic [11:0] ra,
                     input logic ml, input logic mh, input logic [7:0] d);
    bus.nCS = 1'b0;
    {bus.nRAS, bus.nCAS, bus.nRWE} = c;
    bus.BA = ba; bus.RA = ra; bus.DQML = ml; bus.DQMH = mh; bus.RDin = d;
    tick();
    bus.nCS = 1'b1;
    {bus.nRAS, bus.nCAS, bus.nRWE} = 3'b111;
    bus.DQML = 1'b1; bus.DQMH = 1'b1;
  endtask

  task automatic rd(input logic [1:0] ba, input logic [11:0] ra, input logic ml,
                    input logic mh, input logic [7:0] want, input int unsigned extra);
    exp_t e;
    cmd(C_RD, ba, ra, ml, mh, 8'h00);
    if (!(ml && mh)) begin
      e.data = want;
      e.at   = cyc + cl + extra;
      q.push_back(e);
    end
  endtask

  // Monitor: each enabled-edge RDoe pops one expectation; suspended edges must hold data
  always @(negedge clk) begin
    if (bus.RDoe === 1'b1) begin
      checks++;
      if (last_en) begin
        if (q.size() == 0) begin
          $display("FAIL rd_unexpected: got RDoe=1 data=%h at edge %0d, want no read", bus.RDout, cyc);
        end else begin
          mon_e = q.pop_front();
          if (bus.RDout === mon_e.data && cyc == mon_e.at) passes++;
          else $display("FAIL rd_data: got %h at edge %0d, want %h at edge %0d",
                        bus.RDout, cyc, mon_e.data, mon_e.at);
        end
        held = bus.RDout;
      end else begin
        if (bus.RDout === held) passes++;
        else $display("FAIL rd_hold: got %h, want %h", bus.RDout, held);
      end
    end
  end

  initial begin
    bus.CKE = 1'b1; bus.nCS = 1'b1;
    {bus.nRAS, bus.nCAS, bus.nRWE} = 3'b111;
    bus.BA = 2'd0; bus.RA = 12'h000; bus.DQML = 1'b1; bus.DQMH = 1'b1; bus.RDin = 8'h00;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    check("rst_ready",    int'(bus.Ready), 0);
    check("rst_caslat",   int'(bus.CasLat), 2);
    check("rst_rdoe",     int'(bus.RDoe), 0);
    check("rst_refcount", int'(bus.RefCount), 0);
    check("rst_errors",   int'({bus.ErrInit, bus.ErrProto, bus.ErrMode, bus.ErrRef}), 0);

    cmd(C_ACT, 2'd0, 12'h000, 1'b1, 1'b1, 8'h00);
    check("act_before_init_errinit", int'(bus.ErrInit), 1);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("errinit_cleared_by_reset", int'(bus.ErrInit), 0);

    cmd(C_PRE, 2'd0, 12'h400, 1'b1, 1'b1, 8'h00);
    cmd(C_LMR, 2'd0, 12'h220, 1'b1, 1'b1, 8'h00);
    cmd(C_REF, 2'd0, 12'h000, 1'b1, 1'b1, 8'h00);
    check("ready_after_one_aref", int'(bus.Ready), 0);
    cmd(C_REF, 2'd0, 12'h000, 1'b1, 1'b1, 8'h00);
    check("init_ready",    int'(bus.Ready), 1);
    check("init_caslat",   int'(bus.CasLat), 2);
    check("init_errors",   int'({bus.ErrInit, bus.ErrProto, bus.ErrMode, bus.ErrRef}), 0);
    check("init_refcount", int'(bus.RefCount), 2);

    // CL2 write/read, lane masks, second bank, back-to-back reads
    cmd(C_ACT, 2'd1, 12'h003, 1'b1, 1'b1, 8'h00);
    cmd(C_WR,  2'd1, 12'h05A, 1'b0, 1'b1, 8'hC3);
    rd(2'd1, 12'h05A, 1'b0, 1'b1, 8'hC3, 0);
    repeat (3) tick();
    cmd(C_WR, 2'd1, 12'h010, 1'b0, 1'b1, 8'h11);
    cmd(C_WR, 2'd1, 12'h010, 1'b1, 1'b0, 8'h22);
    cmd(C_WR, 2'd1, 12'h010, 1'b1, 1'b1, 8'hFF);
    rd(2'd1, 12'h010, 1'b1, 1'b0, 8'h22, 0);
    rd(2'd1, 12'h010, 1'b0, 1'b1, 8'h11, 0);
    rd(2'd1, 12'h010, 1'b1, 1'b1, 8'h00, 0);
    repeat (4) tick();
    cmd(C_ACT, 2'd2, 12'h007, 1'b1, 1'b1, 8'h00);
    cmd(C_WR,  2'd2, 12'h05A, 1'b0, 1'b1, 8'h77);
    rd(2'd2, 12'h05A, 1'b0, 1'b1, 8'h77, 0);
    rd(2'd1, 12'h05A, 1'b0, 1'b1, 8'hC3, 0);
    repeat (4) tick();

    // Suspend while read pending: data arrives three edges late
    rd(2'd1, 12'h05A, 1'b0, 1'b1, 8'hC3, 3);
    bus.CKE = 1'b0;
    repeat (3) tick();
    bus.CKE = 1'b1;
    repeat (4) tick();

    // Suspend while data is on the bus: RDoe/RDout hold
    rd(2'd1, 12'h010, 1'b1, 1'b0, 8'h22, 0);
    tick();
    bus.CKE = 1'b0;
    repeat (3) tick();
    check("rdoe_held_in_suspend", int'(bus.RDoe), 1);
    check("rdout_held_in_suspend", int'(bus.RDout), 8'h22);
    bus.CKE = 1'b1;
    repeat (4) tick();

    // Pending reads cancelled by WR and by PRE of the same bank
    cmd(C_RD, 2'd1, 12'h010, 1'b1, 1'b0, 8'h00);
    cmd(C_WR, 2'd1, 12'h020, 1'b0, 1'b1, 8'h55);
    repeat (4) tick();
    cmd(C_RD,  2'd2, 12'h05A, 1'b0, 1'b1, 8'h00);
    cmd(C_PRE, 2'd2, 12'h000, 1'b1, 1'b1, 8'h00);
    repeat (4) tick();
    check("no_errproto_yet", int'(bus.ErrProto), 0);

    cmd(C_RD, 2'd2, 12'h05A, 1'b0, 1'b1, 8'h00);
    check("rd_closed_errproto", int'(bus.ErrProto), 1);
    repeat (4) tick();

    cmd(C_PRE, 2'd0, 12'h400, 1'b1, 1'b1, 8'h00);
    cmd(C_LMR, 2'd0, 12'h210, 1'b1, 1'b1, 8'h00);
    check("bad_cl_errmode", int'(bus.ErrMode), 1);
    check("bad_cl_caslat_kept", int'(bus.CasLat), 2);
    cmd(C_LMR, 2'd0, 12'h030, 1'b1, 1'b1, 8'h00);
    check("cl3_caslat", int'(bus.CasLat), 3);
    check("lmr_in_ready_keeps_ready", int'(bus.Ready), 1);
    cl = 3;
    cmd(C_ACT, 2'd1, 12'h003, 1'b1, 1'b1, 8'h00);
    rd(2'd1, 12'h05A, 1'b0, 1'b1, 8'hC3, 0);
    rd(2'd1, 12'h010, 1'b1, 1'b0, 8'h22, 0);
    repeat (5) tick();

    // Refresh interval boundary
    check("errref_before_gap", int'(bus.ErrRef), 0);
    cmd(C_PRE, 2'd0, 12'h400, 1'b1, 1'b1, 8'h00);
    cmd(C_REF, 2'd0, 12'h000, 1'b1, 1'b1, 8'h00);
    check("refcount_three", int'(bus.RefCount), 3);
    repeat (1025) tick();
    check("errref_at_limit", int'(bus.ErrRef), 0);
    tick();
    check("errref_past_limit", int'(bus.ErrRef), 1);

    repeat (70000) cmd(C_REF, 2'd0, 12'h000, 1'b1, 1'b1, 8'h00);
    check("refcount_saturated", int'(bus.RefCount), 32'h0000FFFF);
    check("refcount_errproto_unchanged", int'(bus.ErrProto), 1);

    repeat (3) tick();
    check("reads_outstanding", q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
